sap1_ram_loader: RTL

Memory-address and programming front end for the SAP-1 16×8 program/data RAM, built from two 4-bit RAM chips sharing address and control. In run mode it is the MAR: it captures the low nibble of the W bus and drives the RAM address while the controller owns chip enable. In program mode an FSM accepts a valid/ready stream of 16 bytes and writes them to addresses 0..15. Each write uses a glitch-free, registered write-enable pulse with explicit address/data setup and hold cycles.

---
 rtl/sap1_ram_loader_pkg.sv | 23 ++
 rtl/sap1_mar.sv | 42 ++++
 rtl/sap1_ram_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sap1_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// sap1_ram_loader_pkg
// Shared definitions for the SAP-1 memory front end: default geometry of the
// 16x8 program/data RAM, the write-enable pulse length, and the 3-bit state
// encodings of the RAM loader FSM. Imported by the loader, the MAR, the RAM
// wrapper and the controller so they all agree on widths and encodings.
// -----------------------------------------------------------------------------
package sap1_ram_loader_pkg;

    localparam int ADDR_W_DEF    = 4;   // 16 words
    localparam int DATA_W_DEF    = 8;   // two 4-bit RAM chips side by side
    localparam int WE_CYCLES_DEF = 2;   // ram_n_we low time per write
    localparam int WE_CNT_W      = 4;   // holds WE_CYCLES-1 for WE_CYCLES up to 15

    // Loader FSM state encodings
    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/sap1_mar.sv
// -----------------------------------------------------------------------------
// sap1_mar
// SAP-1 memory address register: a load register with asynchronous clear.
//   clk   : rising-edge clock
//   clr   : asynchronous active-high clear (q -> 0)
//   n_lm  : active-low load; q takes d on the rising edge while low
//   d     : address from the W bus low nibble
//   q     : registered address
// -----------------------------------------------------------------------------
module sap1_mar
    import sap1_ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              n_lm,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] mar_d;

    always_comb begin
        mar_d = mar_q;
        if (!n_lm) begin
            mar_d = d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mar_q <= '0;
        end else begin
            mar_q <= mar_d;
        end
    end

    assign q = mar_q;

endmodule

// File: rtl/sap1_ram_loader.sv
// -----------------------------------------------------------------------------
// sap1_ram_loader
// Address and programming front end for the SAP-1 16x8 RAM.
// Run mode: acts as the MAR (loads bus_in on n_lm low) and passes the
// controller's chip enable through to the RAM.
// Program mode: accepts a valid/ready byte stream and writes it to addresses
// 0..2^ADDR_W-1, each write framed as SETUP / WRITE (ram_n_we low for
// WE_CYCLES cycles) / HOLD with address and data held steady throughout.
//   clk, clr            : clock, asynchronous active-high reset
//   prog                : 1 = program mode, 0 = run mode (level)
//   n_lm, bus_in        : run-mode MAR load strobe (active-low) and W-bus nibble
//   n_ce_run            : run-mode RAM enable from the controller (active-low)
//   load_valid/_data    : program byte stream in
//   load_ready          : loader can accept a byte (IDLE only)
//   ram_a, ram_d        : RAM address / write data
//   ram_n_we, ram_n_ce  : RAM write enable (registered) / chip enable, active-low
//   done                : every word written this program session
// -----------------------------------------------------------------------------
module sap1_ram_loader
    import sap1_ram_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WE_CYCLES = WE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog,
    input  logic              n_lm,
    input  logic [ADDR_W-1:0] bus_in,
    input  logic              n_ce_run,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_n_we,
    output logic              ram_n_ce,
    output logic              done
);

    // Counter is one bit wider than the address so the post-last value is
    // distinct from 0 and can never alias back onto word 0.
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [WE_CNT_W-1:0] WE_LAST = WE_CNT_W'(WE_CYCLES - 1);

    logic [2:0]          state_q,  state_d;
    logic [ADDR_W:0]     cnt_q,    cnt_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
    logic                n_we_q,   n_we_d;

    logic [ADDR_W-1:0]   mar_out;
    logic                mar_n_lm;

    // The MAR only listens to the controller in run mode; in program mode it
    // keeps whatever address it held so run mode resumes where it left off.
    assign mar_n_lm = n_lm | (state_q != ST_RUN);

    sap1_mar #(
        .ADDR_W (ADDR_W)
    ) u_mar (
        .clk  (clk),
        .clr  (clr),
        .n_lm (mar_n_lm),
        .d    (bus_in),
        .q    (mar_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_cnt_d = we_cnt_q;
        case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (prog) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Mode exit wins over a byte offered in the same cycle.
                if (!prog) begin
                    state_d = ST_RUN;
                end else if (load_valid) begin
                    data_d  = load_data;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                we_cnt_d = '0;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (we_cnt_q == WE_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!prog) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Write enable is decoded from the next state so the pin itself is a
        // bare flop output and cannot glitch.
        n_we_d = (state_d != ST_WRITE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_cnt_q <= '0;
            n_we_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_cnt_q <= we_cnt_d;
            n_we_q   <= n_we_d;
        end
    end

    always_comb begin
        ram_n_ce = 1'b1;
        case (state_q)
            ST_RUN:                      ram_n_ce = n_ce_run;
            ST_SETUP, ST_WRITE, ST_HOLD: ram_n_ce = 1'b0;
            default:                     ram_n_ce = 1'b1;
        endcase
    end

    assign ram_a      = (state_q == ST_RUN) ? mar_out : addr_q;
    assign ram_d      = data_q;
    assign ram_n_we   = n_we_q;
    assign load_ready = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule
